// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
//   Shared types and constants for the instruction loader.
//   - state_t   : loader FSM states
//   - INSTR_W   : instruction word width (9 bits)
//   - HALT_WORD : halt/Ack encoding that sets HaltSeen when loaded
//   - LEN_W     : width of the big-endian length header (16 bits)
//   - pack_instr: builds an instruction word from the HI/LO stream bytes
// -----------------------------------------------------------------------------
package inst_loader_pkg;

  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_INST_HI = 3'd3,
    S_INST_LO = 3'd4,
    S_CHK     = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  // Only bit 0 of the HI byte carries instruction data; the rest must be zero
  // and is checked separately by the FSM.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic hi0,
                                                    input logic [7:0] lo);
    return {hi0, lo};
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// -----------------------------------------------------------------------------
// inst_loader_if
//   Bundles the loader's byte-stream handshake, IMEM write port and status.
//   Modports:
//     master : host/test side (drives Start, InByte, InValid)
//     slave  : loader side    (drives InReady, IMEM write port, status)
//   Signals:
//     Start      host requests a new load
//     InByte     stream data byte
//     InValid    InByte valid
//     InReady    loader accepts a byte when InValid & InReady
//     ImemWrEn   one-cycle IMEM write strobe
//     ImemAddr   IMEM write address (PC_W bits)
//     ImemWrData packed 9-bit instruction
//     Busy       load in progress
//     Done       load completed with good checksum (level)
//     Err        load aborted (level)
//     CpuStart   one-cycle pulse when Done first rises
//     HaltSeen   a halt word has been loaded
// -----------------------------------------------------------------------------
interface inst_loader_if
  import inst_loader_pkg::*;
#(
  parameter int PC_W = 10
);

  logic               Start;
  logic [7:0]         InByte;
  logic               InValid;
  logic               InReady;
  logic               ImemWrEn;
  logic [PC_W-1:0]    ImemAddr;
  logic [INSTR_W-1:0] ImemWrData;
  logic               Busy;
  logic               Done;
  logic               Err;
  logic               CpuStart;
  logic               HaltSeen;

  modport master (
    output Start, InByte, InValid,
    input  InReady, ImemWrEn, ImemAddr, ImemWrData,
    input  Busy, Done, Err, CpuStart, HaltSeen
  );

  modport slave (
    input  Start, InByte, InValid,
    output InReady, ImemWrEn, ImemAddr, ImemWrData,
    output Busy, Done, Err, CpuStart, HaltSeen
  );

endinterface

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//   Fills instruction memory from a byte stream. Stream layout:
//     LEN_HI, LEN_LO (word count N, big-endian), N x {HI, LO}, CHK
//   Each word is {HI[0], LO}; HI[7:1] must be zero. CHK is the XOR of every
//   preceding byte. Words go to IMEM addresses 0..N-1, one write strobe the
//   cycle after each LO byte. A good checksum ends in DONE with a CpuStart
//   pulse; any violation ends in ERR (already-written words are kept).
//
//   Ports:
//     Clk     : system clock, rising edge
//     Reset_n : asynchronous active-low reset
//     bus     : inst_loader_if.slave (handshake, IMEM write port, status)
//
//   Parameter PC_W: IMEM address width, capacity 2**PC_W words.
// -----------------------------------------------------------------------------
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  inst_loader_if.slave bus
);

  // One bit wider than the header so N == 2**PC_W is representable even when
  // PC_W equals the header width.
  localparam logic [LEN_W:0] CAP = (LEN_W+1)'(1) << PC_W;

  state_t             state;
  logic [7:0]         len_hi;
  logic [7:0]         chk;
  logic [LEN_W-1:0]   rem;
  logic [PC_W-1:0]    idx;
  logic               hi0;

  logic               take;
  logic [LEN_W-1:0]   hdr_len;
  logic [INSTR_W-1:0] word;

  // Ready is a pure decode of the state register, so it never depends on
  // InValid within the same cycle.
  assign bus.InReady = (state == S_LEN_HI)  || (state == S_LEN_LO) ||
                       (state == S_INST_HI) || (state == S_INST_LO) ||
                       (state == S_CHK);
  assign bus.Busy    = bus.InReady;
  assign take        = bus.InValid & bus.InReady;
  assign hdr_len     = {len_hi, bus.InByte};
  assign word        = pack_instr(hi0, bus.InByte);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= S_IDLE;
      len_hi         <= '0;
      chk            <= '0;
      rem            <= '0;
      idx            <= '0;
      hi0            <= 1'b0;
      bus.ImemWrEn   <= 1'b0;
      bus.ImemAddr   <= '0;
      bus.ImemWrData <= '0;
      bus.Done       <= 1'b0;
      bus.Err        <= 1'b0;
      bus.CpuStart   <= 1'b0;
      bus.HaltSeen   <= 1'b0;
    end else begin
      // Strobes default low; address/data hold their last value.
      bus.ImemWrEn <= 1'b0;
      bus.CpuStart <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.Start) begin
            state        <= S_LEN_HI;
            bus.Done     <= 1'b0;
            bus.Err      <= 1'b0;
            bus.HaltSeen <= 1'b0;
            chk          <= '0;
            idx          <= '0;
          end
        end

        S_LEN_HI: begin
          if (take) begin
            len_hi <= bus.InByte;
            chk    <= chk ^ bus.InByte;
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (take) begin
            chk <= chk ^ bus.InByte;
            rem <= hdr_len;
            if ({1'b0, hdr_len} > CAP) begin
              state   <= S_ERR;
              bus.Err <= 1'b1;
            end else if (hdr_len == '0) begin
              state <= S_CHK;
            end else begin
              state <= S_INST_HI;
            end
          end
        end

        S_INST_HI: begin
          if (take) begin
            chk <= chk ^ bus.InByte;
            if (bus.InByte[7:1] != 7'd0) begin
              state   <= S_ERR;
              bus.Err <= 1'b1;
            end else begin
              hi0   <= bus.InByte[0];
              state <= S_INST_LO;
            end
          end
        end

        S_INST_LO: begin
          if (take) begin
            chk            <= chk ^ bus.InByte;
            // Registered write: the strobe appears the cycle after the LO byte.
            bus.ImemWrEn   <= 1'b1;
            bus.ImemAddr   <= idx;
            bus.ImemWrData <= word;
            if (word == HALT_WORD) bus.HaltSeen <= 1'b1;
            idx <= idx + PC_W'(1);
            rem <= rem - LEN_W'(1);
            // rem still holds the count before this word, so 1 means last.
            state <= (rem == LEN_W'(1)) ? S_CHK : S_INST_HI;
          end
        end

        S_CHK: begin
          if (take) begin
            // The checksum byte itself is not folded into chk.
            if (bus.InByte == chk) begin
              state        <= S_DONE;
              bus.Done     <= 1'b1;
              bus.CpuStart <= 1'b1;
            end else begin
              state   <= S_ERR;
              bus.Err <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer-side counterpart of the instruction decoder. It fills instruction memory with 9-bit machine words that the fetch/decode path later reads.
- Accepts a byte stream over a valid/ready handshake, packs each pair of bytes into one 9-bit instruction, and writes the words to sequential IMEM addresses from 0.
- Verifies a length header and a trailing XOR checksum, then releases the CPU with a start pulse.
- Sits between the host/test interface and the instruction memory write port.

Parameters:
- PC_W, 10, IMEM address width; capacity is 2**PC_W words.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin a load; honoured only in IDLE, DONE or ERR.
- InByte  in  8  stream data.
- InValid  in  1  InByte is valid.
- InReady  out  1  loader can accept a byte; a byte transfers when InValid & InReady.
- ImemWrEn  out  1  one-cycle IMEM write strobe.
- ImemAddr  out  PC_W  IMEM write address.
- ImemWrData  out  9  instruction word to write.
- Busy  out  1  load in progress.
- Done  out  1  load completed with a good checksum (level).
- Err  out  1  load aborted (level).
- CpuStart  out  1  one-cycle pulse in the first cycle Done is high.
- HaltSeen  out  1  at least one loaded word equals 9'h1FF (halt/Ack encoding).

Behaviour:
- Reset (async, Reset_n=0): state IDLE. ImemWrEn=0, ImemAddr=0, ImemWrData=0, Busy=0, Done=0, Err=0, CpuStart=0, HaltSeen=0, InReady=0. Internal count and checksum cleared.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N pairs {HI, LO}, then CHK.
  - Each word: instr = {HI[0], LO}. HI[7:1] must be 0.
  - CHK must equal the XOR of every preceding byte, including the length bytes.
- States: IDLE, LEN_HI, LEN_LO, INST_HI, INST_LO, CHK, DONE, ERR.
  - IDLE/DONE/ERR --Start--> LEN_HI. Clears Done, Err and HaltSeen; checksum=0; word index=0.
  - LEN_HI --byte--> LEN_LO.
  - LEN_LO --byte--> ERR if N > 2**PC_W; else CHK if N==0; else INST_HI.
  - INST_HI --byte--> ERR if HI[7:1]!=0; else INST_LO.
  - INST_LO --byte--> INST_HI if the current word is not the last; else CHK.
  - CHK --byte--> DONE if the byte equals the running checksum; else ERR.
- Each accepted byte is XORed into the checksum, except the CHK byte itself.
- InReady=1 exactly in LEN_HI, LEN_LO, INST_HI, INST_LO and CHK. It is decoded from registered state, with no combinational path from InValid.
- Busy=1 in the same states as InReady.
- No byte is consumed in a cycle with InValid=0. Gaps of any length are legal and do not alter state.
- Write timing: the cycle after an INST_LO byte is accepted, ImemWrEn=1 for exactly 1 cycle.
  - ImemAddr = index of that word; ImemWrData = the packed word.
  - Index increments after each write. ImemAddr/ImemWrData hold their last value when ImemWrEn=0.
  - A back-to-back HI/LO stream produces at most one write every 2 cycles.
- N==2**PC_W is legal. The last address is 2**PC_W-1, and the index does not wrap before CHK.
- HaltSeen is set in the write cycle of any 9'h1FF word and stays set until the next Start or reset.
- Done is set on entering DONE and CpuStart pulses in that same cycle. Err is set on entering ERR; CpuStart never fires on error.
- Words written before an error remain in IMEM. The loader does no rollback.
- Start while Busy is ignored.
- Start in the same cycle as a pending write: the write still completes; the restart takes effect per the state rules.
- Reset mid-load returns everything to reset values immediately. A pending write strobe is dropped.

Decomposition:
- Shared package:
  - state enum type
  - INSTR_W=9
  - HALT_WORD=9'h1FF
  - the header-length width (16)
- Single module with no sub-module. The FSM, counter and checksum are small enough to stay flat.

Test Plan:
- Load 3 words with PC_W=10, bytes 00 03 00 A3 01 FF 01 05 5A -> writes (0,0x0A3), (1,0x1FF), (2,0x105); HaltSeen=1; Done=1; one CpuStart pulse; Err=0.
- Same stream with CHK=5B -> three writes occur, then Err=1, Done=0, no CpuStart, InReady=0.
- Empty load, bytes 00 00 00 -> no ImemWrEn; Done=1; CpuStart pulse.
- Bad HI byte: 00 01 02 34 -> Err=1 after byte 02, no write, 34 not accepted. Oversize length with PC_W=4: 00 11 -> Err=1 after LEN_LO.
- Backpressure: the 3-word stream with InValid toggling 1-0-0-1 -> identical writes and Done; no byte consumed while InValid=0.
- Reset_n low for 1 cycle after the second word's write, then a full 3-word reload -> all outputs return to 0 at once, and the reload writes addresses from 0.
